// File: rtl/mmuart_pkg.sv
// Shared constants and sequencer state type for the MMUART transmit path.
// Used by mmuart_txfifo and mmuart_txfifo_ram.
package mmuart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEPTH_LOG2_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_state_e;
endpackage

// File: rtl/mmuart_txfifo_ram.sv
// Byte storage for the UART transmit FIFO.
// One write port, one asynchronous read port, contents never reset.
module mmuart_txfifo_ram
  import mmuart_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmuart_txfifo.sv
// UART transmit FIFO with launch sequencer (one byte in flight at a time).
// Define MMUART_TXFIFO_LEVEL_EN to add the level and thresh_irq outputs.
module mmuart_txfifo
  import mmuart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              flush,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
`ifdef MMUART_TXFIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0] level,
  output logic              thresh_irq,
`endif
  output logic              idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [BYTE_W-1:0]     rd_data;
  tx_state_e             state;
  tx_state_e             state_nxt;
  logic                  launch;
  logic                  push;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign idle  = empty && (state == IDLE);
  assign push  = wr_en && !full && !flush;

  mmuart_txfifo_ram #(
    .AW(DEPTH_LOG2)
  ) u_ram (
    .clk  (sys_clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Only IDLE may launch, so a busy transmitter is never re-strobed.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !flush) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      flush:            count_nxt = '0;
      push && !launch:  count_nxt = count + 1'b1;
      launch && !push:  count_nxt = count - 1'b1;
      default:          count_nxt = count;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_wr    <= 1'b0;
      tx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      tx_wr    <= launch;
      overflow <= wr_en && full;
      if (launch) tx_data <= rd_data;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (launch) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef MMUART_TXFIFO_LEVEL_EN
  assign level = count;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) thresh_irq <= 1'b1;
    else         thresh_irq <= (count_nxt <= (CNT_FULL >> 1));
  end
`endif

endmodule

// File: tb/tb_mmuart_txfifo.sv
// Randomised scoreboard bench for mmuart_txfifo (DEPTH_LOG2 = 4).
// A queue-based reference model predicts launches, flags and overflow.
module tb_mmuart_txfifo;

  localparam int DL2 = 4;
  localparam int DEPTH = 16;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       idle;
`ifdef MMUART_TXFIFO_LEVEL_EN
  logic [DL2:0] level;
  logic       thresh_irq;
`endif

  mmuart_txfifo #(
    .DEPTH_LOG2(DL2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .flush   (flush),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_done (tx_done),
`ifdef MMUART_TXFIFO_LEVEL_EN
    .level     (level),
    .thresh_irq(thresh_irq),
`endif
    .idle    (idle)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  bit         busy = 0;
  bit         exp_tx_wr = 0;
  bit         exp_ovf = 0;
  logic [7:0] exp_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_q.delete();
    busy = 0;
    exp_tx_wr = 0;
    exp_ovf = 0;
    exp_last = 8'h00;
  endtask

  // One clock edge of the reference behaviour, from pre-edge occupancy.
  task automatic model_step();
    int s;
    bit go;
    logic [7:0] b;
    s = q.size();
    go = !busy && s > 0 && !flush;
    exp_ovf = wr_en && s == DEPTH;
    exp_tx_wr = go;
    if (flush) begin
      q.delete();
    end else begin
      if (go) begin
        b = q.pop_front();
        exp_q.push_back(b);
        exp_last = b;
      end
      if (wr_en && s < DEPTH) q.push_back(wr_data);
    end
    if (busy && tx_done) busy = 0;
    else if (go) busy = 1;
  endtask

  task automatic cyc(input logic we, input logic [7:0] d,
                     input logic fl, input logic td);
    @(negedge sys_clk);
    #1;
    wr_en = we;
    wr_data = d;
    flush = fl;
    tx_done = td;
    @(posedge sys_clk);
    if (!sys_rst) model_step();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    wr_en = 0;
    flush = 0;
    tx_done = 0;
    model_reset();
    #1;
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_empty", empty, 1);
    chk("rst_idle", idle, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tx_data", tx_data, 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge sys_clk);
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("idle", idle, q.size() == 0 && !busy);
      chk("overflow", overflow, exp_ovf);
      chk("tx_wr", tx_wr, exp_tx_wr);
      if (tx_wr) begin
        if (exp_q.size() == 0) begin
          chk("launch_unexpected", tx_wr, 0);
        end else begin
          b = exp_q.pop_front();
          chk("tx_byte", tx_data, b);
        end
      end
      chk("tx_data_hold", tx_data, exp_last);
`ifdef MMUART_TXFIFO_LEVEL_EN
      chk("level", level, q.size());
      chk("thresh_irq", thresh_irq, q.size() <= DEPTH / 2);
`endif
    end
  end

  initial begin
    sys_rst = 1'b1;
    wr_en = 0;
    wr_data = 0;
    flush = 0;
    tx_done = 0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b0;

    // single byte, then stray tx_done while idle
    cyc(1, 8'h41, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1);

    // fill to full while busy, overflow, then drain in order
    cyc(1, 8'hAA, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hFF, 0, 0);
    cyc(1, 8'hEE, 0, 1);
    for (int i = 0; i < 60; i++) cyc(0, 0, 0, (i % 3) == 2);

    // push coinciding with pop at count 3
    cyc(1, 8'h50, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'h51 + 8'(i), 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 8'h60, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, i[0]);

    // flush while a byte is in flight
    cyc(1, 8'h70, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h71 + 8'(i), 0, 0);
    cyc(1, 8'h7F, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);

    // reset mid-transmission
    cyc(1, 8'h80, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h81 + 8'(i), 0, 0);
    do_reset();
    cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 1) == 1, 8'($urandom),
          $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 1'b0,
          $urandom_range(0, 7) == 0);

    // drain
    for (int i = 0; i < 80; i++) cyc(0, 0, 0, i[0]);
    @(negedge sys_clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
